// File: rtl/video_raster_pos.sv
// video_raster_pos: raster position tracker fed by the cleaned sync stage.
// Produces a registered data-enable, active-pixel coordinates, the
// measured active width/height of the incoming mode and a stability flag
// with a one-cycle mode-change pulse for downstream OSD/scaler/crop logic.
module video_raster_pos #(
  parameter int XW            = 11,
  parameter int YW            = 10,
  parameter int STABLE_FRAMES = 3
) (
  input  logic          clk32,
  input  logic          reset,
  input  logic          pause,
  input  logic          ce,
  input  logic          hblank,
  input  logic          vblank,
  input  logic          ilace,
  input  logic          field,
  output logic          de,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [XW-1:0] hactive,
  output logic [YW-1:0] vactive,
  output logic          stable,
  output logic          mode_change,
  output logic          frame_start
);

  // Stability counter only needs to reach STABLE_FRAMES (at most 15).
  localparam logic [3:0] STABLE_MAX = 4'(STABLE_FRAMES);

  logic          tick_s;
  logic          line_end_s;
  logic          frame_end_s;
  logic          frame_start_s;
  logic [XW-1:0] hcnt_inc_s;
  logic [YW-1:0] vcnt_inc_s;

  logic          hb_q, hb_d;
  logic          vb_q, vb_d;
  logic [XW-1:0] hcnt_q, hcnt_d;
  logic [YW-1:0] vcnt_q, vcnt_d;
  logic [XW-1:0] line_w_q, line_w_d;
  logic [XW-1:0] hactive_q, hactive_d;
  logic [YW-1:0] vactive_q, vactive_d;
  logic          ilace_l_q, ilace_l_d;
  logic [3:0]    scnt_q, scnt_d;
  logic          stable_q, stable_d;
  logic          mode_change_q, mode_change_d;
  logic          frame_start_q, frame_start_d;
  logic          de_q, de_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  // Tick qualification, sync-edge events and saturating increments.
  always_comb begin
    tick_s        = ce & ~pause;
    line_end_s    = tick_s & hblank & ~hb_q & ~vb_q;
    frame_end_s   = tick_s & vblank & ~vb_q;
    frame_start_s = tick_s & ~vblank & vb_q;
    if (&hcnt_q) begin
      hcnt_inc_s = hcnt_q;
    end else begin
      hcnt_inc_s = hcnt_q + XW'(1);
    end
    if (&vcnt_q) begin
      vcnt_inc_s = vcnt_q;
    end else begin
      vcnt_inc_s = vcnt_q + YW'(1);
    end
  end

  // Next-state: counters, measurement latch, stability tracking, outputs.
  always_comb begin
    hb_d          = hb_q;
    vb_d          = vb_q;
    hcnt_d        = hcnt_q;
    vcnt_d        = vcnt_q;
    line_w_d      = line_w_q;
    hactive_d     = hactive_q;
    vactive_d     = vactive_q;
    ilace_l_d     = ilace_l_q;
    scnt_d        = scnt_q;
    mode_change_d = 1'b0;
    frame_start_d = 1'b0;
    de_d          = de_q;
    x_d           = x_q;
    y_d           = y_q;

    if (tick_s) begin
      hb_d = hblank;
      vb_d = vblank;

      // Horizontal position counts active pixels only.
      if (hblank) begin
        hcnt_d = '0;
      end else if (!vblank) begin
        hcnt_d = hcnt_inc_s;
      end else begin
        hcnt_d = hcnt_q;
      end

      // Line end and vertical-blank clearing are exclusive on vb_q.
      if (line_end_s) begin
        line_w_d = hcnt_q;
        vcnt_d   = vcnt_inc_s;
      end else if (vblank && vb_q) begin
        vcnt_d = '0;
      end else begin
        vcnt_d = vcnt_q;
      end

      // Frame end uses the post-line-end measurement so a coincident
      // hblank/vblank rise still counts the last line.
      if (frame_end_s) begin
        if ({line_w_d, vcnt_d, ilace} == {hactive_q, vactive_q, ilace_l_q}) begin
          if (scnt_q == STABLE_MAX) begin
            scnt_d = scnt_q;
          end else begin
            scnt_d = scnt_q + 4'd1;
          end
        end else begin
          hactive_d     = line_w_d;
          vactive_d     = vcnt_d;
          ilace_l_d     = ilace;
          scnt_d        = 4'd0;
          mode_change_d = 1'b1;
        end
      end else begin
        scnt_d = scnt_q;
      end

      frame_start_d = frame_start_s;
      de_d          = ~hblank & ~vblank;
      x_d           = hcnt_q;
      if (ilace) begin
        y_d = {vcnt_q[YW-2:0], field};
      end else begin
        y_d = vcnt_q;
      end
    end else begin
      hb_d = hb_q;
    end
  end

  // Stability is registered alongside the counter it reflects.
  always_comb begin
    stable_d = (scnt_d == STABLE_MAX);
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk32) begin
    if (reset) begin
      hb_q          <= 1'b0;
      vb_q          <= 1'b0;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      line_w_q      <= '0;
      hactive_q     <= '0;
      vactive_q     <= '0;
      ilace_l_q     <= 1'b0;
      scnt_q        <= 4'd0;
      stable_q      <= 1'b0;
      mode_change_q <= 1'b0;
      frame_start_q <= 1'b0;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
    end else begin
      hb_q          <= hb_d;
      vb_q          <= vb_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      line_w_q      <= line_w_d;
      hactive_q     <= hactive_d;
      vactive_q     <= vactive_d;
      ilace_l_q     <= ilace_l_d;
      scnt_q        <= scnt_d;
      stable_q      <= stable_d;
      mode_change_q <= mode_change_d;
      frame_start_q <= frame_start_d;
      de_q          <= de_d;
      x_q           <= x_d;
      y_q           <= y_d;
    end
  end

  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign hactive     = hactive_q;
  assign vactive     = vactive_q;
  assign stable      = stable_q;
  assign mode_change = mode_change_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_video_raster_pos.sv
// Directed bench for video_raster_pos using small frames to keep runtime short.
module tb_video_raster_pos;
  localparam int XW = 11;
  localparam int YW = 10;
  localparam int HB = 4;   // hblank ticks per line
  localparam int VB = 6;   // extra vblank ticks after the last line

  logic clk32 = 1'b0;
  logic reset = 1'b0, pause = 1'b0, ce = 1'b0;
  logic hblank = 1'b0, vblank = 1'b0, ilace = 1'b0, field = 1'b0;
  logic de, stable, mode_change, frame_start;
  logic [XW-1:0] x, hactive;
  logic [YW-1:0] y, vactive;

  int checks = 0;
  int errors = 0;
  int ce_gap = 0;
  int pix_bad, de_cnt, pause_diff;
  logic fe_mc, fe_stable, fs_at_start;
  logic [45:0] rst_snap, snap;
  int long_pulse = 0;
  logic mc_prev = 1'b0, fs_prev = 1'b0;

  video_raster_pos #(.XW(XW), .YW(YW), .STABLE_FRAMES(3)) dut (
    .clk32(clk32), .reset(reset), .pause(pause), .ce(ce),
    .hblank(hblank), .vblank(vblank), .ilace(ilace), .field(field),
    .de(de), .x(x), .y(y), .hactive(hactive), .vactive(vactive),
    .stable(stable), .mode_change(mode_change), .frame_start(frame_start)
  );

  always #5 clk32 = ~clk32;

  // Pulses must never stay high two consecutive clk32 cycles.
  always @(negedge clk32) begin
    if ((mode_change && mc_prev) || (frame_start && fs_prev)) long_pulse <= long_pulse + 1;
    mc_prev <= mode_change;
    fs_prev <= frame_start;
  end

  task automatic do_tick(input logic hb, input logic vb);
    for (int g = 0; g < ce_gap; g++) begin
      ce = 1'b0; @(posedge clk32); #1;
    end
    hblank = hb; vblank = vb; ce = 1'b1;
    @(posedge clk32); #1;
    ce = 1'b0;
  endtask

  task automatic preamble();
    for (int i = 0; i < 4; i++) do_tick(1'b0, 1'b1);
  endtask

  // One frame: h lines of (w active + HB blank ticks), then VB vblank ticks.
  task automatic gen_frame(input int w, input int h, input logic il, input logic fd,
                           input logic simul, input int rst_line, input int pause_line);
    int xe, ye, vstart;
    logic after_rst, vbv;
    pix_bad = 0; de_cnt = 0; pause_diff = 0;
    fe_mc = 1'b0; fe_stable = 1'b0; fs_at_start = 1'b0; after_rst = 1'b0;
    ilace = il; field = fd;
    vstart = simul ? 0 : 1;
    for (int ln = 0; ln < h; ln++) begin
      for (int i = 0; i < w; i++) begin
        do_tick(1'b0, 1'b0);
        if (de) de_cnt++;
        xe = (after_rst && ln == rst_line) ? i - w / 2 : i;
        if (xe > 2047) xe = 2047;
        ye = after_rst ? ln - rst_line : ln;
        if (il) ye = ye * 2 + int'(fd);
        if (de !== 1'b1 || x !== XW'(xe) || y !== YW'(ye)) pix_bad++;
        if (ln == 0 && i == 0) fs_at_start = frame_start;
        if (ln == rst_line && i == w / 2 - 1) begin
          reset = 1'b1; @(posedge clk32); #1;
          rst_snap = {de, x, y, hactive, vactive, stable, mode_change, frame_start};
          reset = 1'b0; after_rst = 1'b1;
        end
        if (ln == pause_line && i == w / 2 - 1) begin
          snap = {de, x, y, hactive, vactive, stable, mode_change, frame_start};
          for (int k = 0; k < 100; k++) begin
            pause = 1'b1; ce = k[0];
            @(posedge clk32); #1;
            if ({de, x, y, hactive, vactive, stable, mode_change, frame_start} !== snap)
              pause_diff++;
          end
          pause = 1'b0; ce = 1'b0;
        end
      end
      for (int j = 0; j < HB; j++) begin
        vbv = (ln == h - 1) && (j >= vstart);
        do_tick(1'b1, vbv);
        if (de) de_cnt++;
        if (vbv && j == vstart) begin
          fe_mc = mode_change; fe_stable = stable;
        end
      end
    end
    for (int k = 0; k < VB; k++) begin
      do_tick(1'b1, 1'b1);
      if (de) de_cnt++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk32);
    #1;
    checks++; if (de !== 1'b0) begin errors++; $display("FAIL reset_de got %0d want 0", de); end
    checks++; if (x !== '0) begin errors++; $display("FAIL reset_x got %0d want 0", x); end
    checks++; if (y !== '0) begin errors++; $display("FAIL reset_y got %0d want 0", y); end
    checks++; if (hactive !== '0) begin errors++; $display("FAIL reset_hactive got %0d want 0", hactive); end
    checks++; if (vactive !== '0) begin errors++; $display("FAIL reset_vactive got %0d want 0", vactive); end
    checks++; if (stable !== 1'b0) begin errors++; $display("FAIL reset_stable got %0d want 0", stable); end
    checks++; if (mode_change !== 1'b0) begin errors++; $display("FAIL reset_mc got %0d want 0", mode_change); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs got %0d want 0", frame_start); end
    reset = 1'b0;
    @(posedge clk32); #1;
    preamble();
  endtask

  task automatic test_progressive();
    gen_frame(20, 12, 1'b0, 1'b0, 1'b0, -1, -1);
    checks++; if (fe_mc !== 1'b1) begin errors++; $display("FAIL prog_mc got %0d want 1", fe_mc); end
    checks++; if (hactive !== 11'd20) begin errors++; $display("FAIL prog_hactive got %0d want 20", hactive); end
    checks++; if (vactive !== 10'd12) begin errors++; $display("FAIL prog_vactive got %0d want 12", vactive); end
    checks++; if (de_cnt !== 240) begin errors++; $display("FAIL prog_de_cnt got %0d want 240", de_cnt); end
    checks++; if (pix_bad !== 0) begin errors++; $display("FAIL prog_xy got %0d bad want 0", pix_bad); end
    checks++; if (fs_at_start !== 1'b1) begin errors++; $display("FAIL prog_fs got %0d want 1", fs_at_start); end
    gen_frame(20, 12, 1'b0, 1'b0, 1'b0, -1, -1);
    gen_frame(20, 12, 1'b0, 1'b0, 1'b0, -1, -1);
    checks++; if (fe_stable !== 1'b0) begin errors++; $display("FAIL prog_stable3 got %0d want 0", fe_stable); end
    checks++; if (fe_mc !== 1'b0) begin errors++; $display("FAIL prog_mc3 got %0d want 0", fe_mc); end
    gen_frame(20, 12, 1'b0, 1'b0, 1'b0, -1, -1);
    checks++; if (fe_stable !== 1'b1) begin errors++; $display("FAIL prog_stable4 got %0d want 1", fe_stable); end
  endtask

  task automatic test_width_change();
    gen_frame(40, 12, 1'b0, 1'b0, 1'b0, -1, -1);
    checks++; if (fe_mc !== 1'b1) begin errors++; $display("FAIL wc_mc got %0d want 1", fe_mc); end
    checks++; if (fe_stable !== 1'b0) begin errors++; $display("FAIL wc_stable_drop got %0d want 0", fe_stable); end
    checks++; if (hactive !== 11'd40) begin errors++; $display("FAIL wc_hactive got %0d want 40", hactive); end
    gen_frame(40, 12, 1'b0, 1'b0, 1'b0, -1, -1);
    gen_frame(40, 12, 1'b0, 1'b0, 1'b0, -1, -1);
    checks++; if (fe_stable !== 1'b0) begin errors++; $display("FAIL wc_stable2 got %0d want 0", fe_stable); end
    gen_frame(40, 12, 1'b0, 1'b0, 1'b0, -1, -1);
    checks++; if (fe_stable !== 1'b1) begin errors++; $display("FAIL wc_stable3 got %0d want 1", fe_stable); end
  endtask

  task automatic test_interlace();
    gen_frame(40, 12, 1'b1, 1'b0, 1'b0, -1, -1);
    checks++; if (fe_mc !== 1'b1) begin errors++; $display("FAIL il_mc got %0d want 1", fe_mc); end
    checks++; if (vactive !== 10'd12) begin errors++; $display("FAIL il_vactive got %0d want 12", vactive); end
    checks++; if (pix_bad !== 0) begin errors++; $display("FAIL il_y_f0 got %0d bad want 0", pix_bad); end
    gen_frame(40, 12, 1'b1, 1'b1, 1'b0, -1, -1);
    checks++; if (pix_bad !== 0) begin errors++; $display("FAIL il_y_f1 got %0d bad want 0", pix_bad); end
    checks++; if (fe_mc !== 1'b0) begin errors++; $display("FAIL il_mc_f1 got %0d want 0", fe_mc); end
  endtask

  task automatic test_pause_ce();
    ce_gap = 3;
    gen_frame(20, 12, 1'b0, 1'b0, 1'b0, -1, 5);
    checks++; if (pause_diff !== 0) begin errors++; $display("FAIL pause_hold got %0d diffs want 0", pause_diff); end
    checks++; if (pix_bad !== 0) begin errors++; $display("FAIL pause_x_resume got %0d bad want 0", pix_bad); end
    checks++; if (hactive !== 11'd20) begin errors++; $display("FAIL pause_hactive got %0d want 20", hactive); end
    checks++; if (fe_mc !== 1'b1) begin errors++; $display("FAIL pause_mc got %0d want 1", fe_mc); end
    ce_gap = 0;
  endtask

  task automatic test_reset_midframe();
    for (int f = 0; f < 3; f++) gen_frame(20, 12, 1'b0, 1'b0, 1'b0, -1, -1);
    checks++; if (stable !== 1'b1) begin errors++; $display("FAIL rm_pre_stable got %0d want 1", stable); end
    gen_frame(20, 12, 1'b0, 1'b0, 1'b0, 6, -1);
    checks++; if (rst_snap !== 46'd0) begin errors++; $display("FAIL rm_outputs got %h want 0", rst_snap); end
    checks++; if (pix_bad !== 0) begin errors++; $display("FAIL rm_xy got %0d bad want 0", pix_bad); end
    checks++; if (fe_mc !== 1'b1) begin errors++; $display("FAIL rm_trunc_mc got %0d want 1", fe_mc); end
    checks++; if (vactive !== 10'd6) begin errors++; $display("FAIL rm_trunc_vactive got %0d want 6", vactive); end
    gen_frame(20, 12, 1'b0, 1'b0, 1'b0, -1, -1);
    checks++; if (fe_mc !== 1'b1) begin errors++; $display("FAIL rm_full_mc got %0d want 1", fe_mc); end
    checks++; if (vactive !== 10'd12) begin errors++; $display("FAIL rm_full_vactive got %0d want 12", vactive); end
    gen_frame(20, 12, 1'b0, 1'b0, 1'b0, -1, -1);
    gen_frame(20, 12, 1'b0, 1'b0, 1'b0, -1, -1);
    checks++; if (fe_stable !== 1'b0) begin errors++; $display("FAIL rm_stable2 got %0d want 0", fe_stable); end
    gen_frame(20, 12, 1'b0, 1'b0, 1'b0, -1, -1);
    checks++; if (fe_stable !== 1'b1) begin errors++; $display("FAIL rm_stable3 got %0d want 1", fe_stable); end
  endtask

  task automatic test_boundaries();
    gen_frame(2100, 2, 1'b0, 1'b0, 1'b0, -1, -1);
    checks++; if (hactive !== 11'd2047) begin errors++; $display("FAIL bnd_hsat got %0d want 2047", hactive); end
    checks++; if (vactive !== 10'd2) begin errors++; $display("FAIL bnd_h2_vactive got %0d want 2", vactive); end
    checks++; if (pix_bad !== 0) begin errors++; $display("FAIL bnd_xsat got %0d bad want 0", pix_bad); end
    gen_frame(20, 200, 1'b0, 1'b0, 1'b1, -1, -1);
    checks++; if (vactive !== 10'd200) begin errors++; $display("FAIL bnd_simul_vactive got %0d want 200", vactive); end
    checks++; if (hactive !== 11'd20) begin errors++; $display("FAIL bnd_simul_hactive got %0d want 20", hactive); end
    checks++; if (fe_mc !== 1'b1) begin errors++; $display("FAIL bnd_simul_mc got %0d want 1", fe_mc); end
  endtask

  initial begin
    test_reset();
    test_progressive();
    test_width_change();
    test_interlace();
    test_pause_ce();
    test_reset_midframe();
    test_boundaries();
    repeat (2) @(posedge clk32);
    #1;
    checks++; if (long_pulse !== 0) begin errors++; $display("FAIL pulse_width got %0d long pulses want 0", long_pulse); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
